// File: rtl/spi_master_mc_pkg.sv
// Shared widths, FSM state type and request record for the multi-slave SPI master.
package spi_master_mc_pkg;

   localparam int unsigned DWIDTH       = 32;
   localparam int unsigned NSLAVES      = 4;
   localparam int unsigned S_ADDR_WIDTH = $clog2(NSLAVES);
   localparam int unsigned LEN_WIDTH    = $clog2(DWIDTH);
   localparam int unsigned DIV_WIDTH    = 8;
   localparam int unsigned CNT_WIDTH    = LEN_WIDTH + 1;
   localparam int unsigned TOG_WIDTH    = LEN_WIDTH + 2;

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} spi_state_t;

   typedef struct packed {
      logic [S_ADDR_WIDTH-1:0] sel;
      logic                    cpol;
      logic                    cpha;
      logic [LEN_WIDTH-1:0]    len;
      logic [DIV_WIDTH-1:0]    clk_div;
      logic [DWIDTH-1:0]       tx_data;
   } spi_req_t;

   // A zero length field means a full-width word.
   function automatic logic [CNT_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] len);
      return (len == '0) ? CNT_WIDTH'(DWIDTH) : {1'b0, len};
   endfunction

endpackage

// File: rtl/spi_master_mc_clkgen.sv
// SCLK timing: half-period counter plus toggle counter, producing leading/trailing
// edge strobes and the phase-boundary tick used by the transfer FSM.
module spi_master_mc_clkgen
   import spi_master_mc_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  spi_state_t           state_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic [TOG_WIDTH-1:0] nedge_i,
   output logic                 tick_o,
   output logic                 lead_o,
   output logic                 trail_o,
   output logic                 last_o,
   output logic                 done_o
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [TOG_WIDTH-1:0] tog_q;
   logic                 busy;
   logic                 sclk_edge;

   assign busy      = (state_i != StIdle);
   assign tick_o    = busy && (cnt_q == div_i);
   assign done_o    = (tog_q == nedge_i);
   // The first toggle closes SETUP; the rest close XFER half-periods until all are spent.
   assign sclk_edge = tick_o && ((state_i == StSetup) || ((state_i == StXfer) && !done_o));
   assign lead_o    = sclk_edge && !tog_q[0];
   assign trail_o   = sclk_edge && tog_q[0];
   assign last_o    = (tog_q == nedge_i - 1'b1);

   always_ff @(posedge clk_i) begin
      if (rst_i || load_i) begin
         cnt_q <= '0;
         tog_q <= '0;
      end else if (busy) begin
         cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
         if (sclk_edge) begin
            tog_q <= tog_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_master_mc.sv
// Mode-configurable multi-slave SPI master: request latch, transfer FSM,
// tx/rx shift registers and chip-select decode.
module spi_master_mc
   import spi_master_mc_pkg::*;
#(
   parameter int unsigned NumSlaves = NSLAVES
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   output logic                    ready_o,
   input  logic [S_ADDR_WIDTH-1:0] slave_sel_i,
   input  logic                    cpol_i,
   input  logic                    cpha_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   input  logic [DIV_WIDTH-1:0]    clk_div_i,
   input  logic [DWIDTH-1:0]       tx_data_i,
   output logic [DWIDTH-1:0]       rx_data_o,
   output logic                    rx_valid_o,
   output logic                    rx_err_o,
   output logic                    sclk_o,
   output logic                    mosi_o,
   input  logic                    miso_i,
   output logic [NumSlaves-1:0]    cs_n_o
);

   spi_state_t           state_q;
   spi_req_t             req_q;
   logic [DWIDTH-1:0]    rx_sh_q;
   logic [DWIDTH-1:0]    rx_data_q;
   logic                 rx_valid_q;
   logic                 rx_err_q;
   logic                 sclk_q;
   logic                 mosi_q;
   logic [NumSlaves-1:0] cs_n_q;

   logic                 accept;
   logic [CNT_WIDTH-1:0] len_in;
   logic [DWIDTH-1:0]    tx_aligned;
   logic [NumSlaves-1:0] cs_dec;
   logic [TOG_WIDTH-1:0] nedge;
   logic                 tick, lead, trail, last, done;
   logic                 sample, drive;

   assign accept     = start_i && (state_q == StIdle);
   assign len_in     = eff_len(len_i);
   // Left-justify so the word's MSB (bit len-1) always leaves from the top of the register.
   assign tx_aligned = tx_data_i << (CNT_WIDTH'(DWIDTH) - len_in);
   assign nedge      = {eff_len(req_q.len), 1'b0};
   assign sample     = req_q.cpha ? trail : lead;
   assign drive      = req_q.cpha ? lead : (trail && !last);

   always_comb begin
      cs_dec = '1;
      for (int unsigned i = 0; i < NumSlaves; i++) begin
         cs_dec[i] = (slave_sel_i != S_ADDR_WIDTH'(i));
      end
   end

   spi_master_mc_clkgen u_clkgen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (accept),
      .state_i (state_q),
      .div_i   (req_q.clk_div),
      .nedge_i (nedge),
      .tick_o  (tick),
      .lead_o  (lead),
      .trail_o (trail),
      .last_o  (last),
      .done_o  (done)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         req_q      <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               sclk_q <= cpol_i;
               mosi_q <= 1'b0;
               if (accept) begin
                  req_q.sel     <= slave_sel_i;
                  req_q.cpol    <= cpol_i;
                  req_q.cpha    <= cpha_i;
                  req_q.len     <= len_i;
                  req_q.clk_div <= clk_div_i;
                  req_q.tx_data <= cpha_i ? tx_aligned : (tx_aligned << 1);
                  mosi_q        <= cpha_i ? 1'b0 : tx_aligned[DWIDTH-1];
                  rx_sh_q       <= '0;
                  cs_n_q        <= cs_dec;
                  state_q       <= StSetup;
               end
            end
            StSetup: begin
               if (tick) begin
                  state_q <= StXfer;
               end
            end
            StXfer: begin
               if (tick && done) begin
                  state_q <= StHold;
               end
            end
            StHold: begin
               sclk_q <= req_q.cpol;
               if (tick) begin
                  state_q    <= StIdle;
                  cs_n_q     <= '1;
                  rx_valid_q <= 1'b1;
                  rx_err_q   <= (32'(req_q.sel) >= NumSlaves);
                  rx_data_q  <= rx_sh_q;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (lead || trail) begin
            sclk_q <= ~sclk_q;
         end
         if (sample) begin
            rx_sh_q <= {rx_sh_q[DWIDTH-2:0], miso_i};
         end
         if (drive) begin
            mosi_q        <= req_q.tx_data[DWIDTH-1];
            req_q.tx_data <= req_q.tx_data << 1;
         end
      end
   end

   assign ready_o    = (state_q == StIdle);
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_err_o   = rx_err_q;
   assign sclk_o     = sclk_q;
   assign mosi_o     = mosi_q;
   assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Randomised bench for spi_master_mc against an edge-driven SPI slave model and
// expected transfer timing computed from mode, length and divider.
module tb_spi_master_mc;
   import spi_master_mc_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst, start, cpol, cpha, miso;
   logic [S_ADDR_WIDTH-1:0] sel;
   logic [LEN_WIDTH-1:0]    len;
   logic [DIV_WIDTH-1:0]    div;
   logic [DWIDTH-1:0]       tx;

   logic              ready, rx_valid, rx_err, sclk, mosi;
   logic [DWIDTH-1:0] rx_data;
   logic [3:0]        cs_n;
   logic              ready3, rx_valid3, rx_err3, sclk3, mosi3;
   logic [DWIDTH-1:0] rx_data3;
   logic [2:0]        cs3_n;

   int n_tests = 0;
   int n_fail  = 0;

   // Slave model state
   bit          loop_en = 1'b0;
   bit          s_active = 1'b0;
   bit          s_cpol, s_cpha, s_lead;
   logic        s_prev = 1'b0;
   logic        s_miso = 1'b0;
   logic [31:0] s_resp, s_cap;
   int          s_idx, s_ncap;

   assign miso = loop_en ? mosi : s_miso;

   always #5 clk = ~clk;

   spi_master_mc dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready), .slave_sel_i(sel),
      .cpol_i(cpol), .cpha_i(cpha), .len_i(len), .clk_div_i(div), .tx_data_i(tx),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_err_o(rx_err), .sclk_o(sclk),
      .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
   );

   spi_master_mc #(.NumSlaves(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready3), .slave_sel_i(sel),
      .cpol_i(cpol), .cpha_i(cpha), .len_i(len), .clk_div_i(div), .tx_data_i(tx),
      .rx_data_o(rx_data3), .rx_valid_o(rx_valid3), .rx_err_o(rx_err3), .sclk_o(sclk3),
      .mosi_o(mosi3), .miso_i(miso), .cs_n_o(cs3_n)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lmask(input int l);
      return (l >= 32) ? 32'hFFFF_FFFF : ((32'd1 << l) - 32'd1);
   endfunction

   // Slave: away from idle level is the leading edge; capture on the sampling edge
   // for the mode, present the next response bit on the other edge.
   always @(negedge clk) begin
      if (s_active && (sclk !== s_prev)) begin
         s_lead = (sclk !== s_cpol);
         if (s_lead != s_cpha) begin
            s_cap = {s_cap[30:0], mosi};
            s_ncap++;
         end else if (!s_cpha) begin
            s_idx--;
            s_miso = (s_idx >= 0) ? s_resp[s_idx] : 1'b0;
         end else begin
            s_miso = (s_idx >= 0) ? s_resp[s_idx] : 1'b0;
            s_idx--;
         end
      end
      s_prev = sclk;
   end

   task automatic run_txn(input int s, input bit pol, input bit pha, input int l, input int d,
                          input logic [31:0] t, input logic [31:0] r, input bit lp);
      int          L, H, lat, k;
      logic [31:0] exp_rx;
      logic [3:0]  exp_cs, cs_seen;
      logic [2:0]  exp_cs3, cs3_seen;
      L       = (l == 0) ? 32 : l;
      H       = d + 1;
      lat     = H * (2 * L + 2);
      exp_cs  = 4'hF & ~(4'd1 << s);
      exp_cs3 = (s < 3) ? (3'h7 & ~(3'd1 << s)) : 3'h7;
      @(negedge clk);
      sel = S_ADDR_WIDTH'(s); cpol = pol; cpha = pha; len = LEN_WIDTH'(l);
      div = DIV_WIDTH'(d); tx = t; loop_en = lp;
      s_resp = r; s_cpol = pol; s_cpha = pha; s_idx = L - 1; s_cap = '0; s_ncap = 0;
      s_miso = pha ? 1'b0 : r[L-1];
      repeat (2) @(negedge clk);
      check("ready_idle", ready, 1);
      start = 1'b1; s_active = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      // Post-accept changes must not affect the transfer in flight
      tx = $urandom; len = LEN_WIDTH'($urandom); div = DIV_WIDTH'($urandom);
      k = 0; cs_seen = exp_cs; cs3_seen = exp_cs3;
      while (rx_valid !== 1'b1 && k < 2 * lat + 20) begin
         if (cs_n !== exp_cs) cs_seen = cs_n;
         if (cs3_n !== exp_cs3) cs3_seen = cs3_n;
         @(negedge clk);
         k++;
      end
      s_active = 1'b0;
      exp_rx = (lp ? t : r) & lmask(L);
      check("latency", k, lat);
      check("rx_data", rx_data, exp_rx);
      check("rx_err", rx_err, 0);
      check("cs_n_xfer", cs_seen, exp_cs);
      check("cs3_xfer", cs3_seen, exp_cs3);
      check("cs_n_done", cs_n, 4'hF);
      check("sclk_idle", sclk, pol);
      check("ready_done", ready, 1);
      check("dut3_valid", rx_valid3, 1);
      check("dut3_err", rx_err3, (s >= 3));
      check("dut3_rx", rx_data3, exp_rx);
      check("slv_nbits", s_ncap, L);
      check("slv_mosi", s_cap & lmask(L), t & lmask(L));
      @(negedge clk);
      check("valid_pulse", rx_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          nv, gap, cnt;
      logic [31:0] rx1, rx2;
      logic [3:0]  cs1, cs2;
      rst = 1'b1; start = 1'b0; sel = '0; cpol = 1'b1; cpha = 1'b0;
      len = '0; div = '0; tx = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_err", rx_err, 0);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_cs_n", cs_n, 4'hF);
      rst = 1'b0; cpol = 1'b0;

      // Directed cases
      run_txn(1, 0, 0, 8, 0, 32'hA5, 32'h0, 1);
      run_txn(0, 1, 1, 0, 3, 32'hDEAD_BEEF, 32'h1234_5678, 0);
      run_txn(2, 0, 1, 5, 1, 32'h13, $urandom, 0);
      run_txn(3, 1, 0, 5, 2, 32'h13, $urandom, 0);

      // Back-to-back with start held high
      @(negedge clk);
      sel = 0; cpol = 0; cpha = 0; len = 8; div = 1; tx = 32'h3C; loop_en = 1; s_active = 0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sel = 2; tx = 32'hC3;
      nv = 0; gap = 0; rx1 = '0; rx2 = '0; cs1 = 4'hF; cs2 = 4'hF;
      for (int k = 0; k < 400 && nv < 2; k++) begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            nv++;
            if (nv == 1) rx1 = rx_data;
            else begin
               rx2 = rx_data;
               start = 1'b0;
            end
         end
         if (nv == 1 && cs_n === 4'hF) gap++;
         if (nv == 0 && cs_n !== 4'hF) cs1 = cs_n;
         if (nv == 1 && cs_n !== 4'hF) cs2 = cs_n;
      end
      start = 1'b0;
      check("b2b_pulses", nv, 2);
      check("b2b_cs_gap", gap, 1);
      check("b2b_rx1", rx1, 32'h3C);
      check("b2b_rx2", rx2, 32'hC3);
      check("b2b_cs1", cs1, 4'b1110);
      check("b2b_cs2", cs2, 4'b1011);
      repeat (3) @(negedge clk);

      // Reset in the middle of a 16-bit transfer
      sel = 1; cpol = 1; cpha = 1; len = 16; div = 1; tx = $urandom; loop_en = 1;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      check("busy_pre_rst", ready, 0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_cs_n", cs_n, 4'hF);
      check("mid_rst_cs3_n", cs3_n, 3'h7);
      check("mid_rst_sclk", sclk, 0);
      check("mid_rst_ready", ready, 1);
      check("mid_rst_valid", rx_valid, 0);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rx_valid === 1'b1) cnt++;
      end
      check("post_rst_no_valid", cnt, 0);
      run_txn(1, 0, 0, 16, 1, $urandom, $urandom, 0);

      // Randomised transfers
      for (int i = 0; i < 12; i++) begin
         run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31), $urandom_range(0, 3), $urandom, $urandom,
                 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
